obuf_multi_tag_ctrl: RTL and testbench
======================================

OBUF_MULTI_TAG_CTRL -- requirements
Module: obuf_multi_tag_ctrl

Interface
REQ-001 Parameter NUM_TAGS, default 2, number of output-buffer tags; power of two, 2..8.
REQ-002 Parameter REUSE_CNT_W, default 3, width of each per-tag pending-compute counter.
REQ-003 Parameter STORE_ENABLED, default 1; 0 means a finished tag returns to FREE without a store pass.
REQ-004 Derived TAG_W = max(1, clog2(NUM_TAGS)).
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 tag_req  in  1  request a new tag; tag_ready  out  1  tag at alloc_ptr is FREE; alloc_tag_id  out  TAG_W  tag granted on accept.
REQ-008 tag_reuse  in  1  one more compute pass on the newest tag; tag_flush  in  1  newest tag has no further reuse.
REQ-009 tag_bias_prev_sw, tag_ddr_pe_sw  in  1 each  sideband values captured on accept or reuse.
REQ-010 ldmem_tag_ready  out  1, ldmem_tag_id  out  TAG_W, ldmem_tag_done  in  1.
REQ-011 compute_tag_ready  out  1, compute_tag_id  out  TAG_W, compute_tag_done  in  1, compute_bias_prev_sw  out  1, next_compute_tag  out  1  one-cycle retire pulse.
REQ-012 stmem_tag_ready  out  1, stmem_tag_id  out  TAG_W, stmem_tag_done  in  1, stmem_ddr_pe_sw  out  1.
REQ-013 tags_free  out  TAG_W+1  count of tags in FREE; reuse_overflow  out  1  sticky error flag.

Function
REQ-014 Each tag runs a state machine: FREE -> LDMEM -> COMPUTE <-> COMPUTE_CHECK -> STMEM -> FREE; with STORE_ENABLED=0, COMPUTE_CHECK goes directly to FREE.
REQ-015 Four pointers: alloc_ptr, ldmem_ptr, compute_ptr, stmem_ptr. Each advances by 1 mod NUM_TAGS only when its stage hands off, so tags complete strictly in allocation order.
REQ-016 A request is accepted when tag_req && tag_ready. On accept: tag[alloc_ptr] -> LDMEM, count = 1, flushed = 0, sideband captured, alloc_tag_id = alloc_ptr, and alloc_ptr advances.
REQ-017 ldmem_tag_ready = tag[ldmem_ptr] in LDMEM. On ldmem_tag_done while ready: the tag -> COMPUTE and ldmem_ptr advances. A done pulse while not ready is ignored.
REQ-018 compute_tag_ready = tag[compute_ptr] in COMPUTE. On compute_tag_done while ready: count decrements and the tag -> COMPUTE_CHECK.
REQ-019 In COMPUTE_CHECK: if count != 0, the tag -> COMPUTE. If count == 0 and flushed, the tag -> STMEM (or FREE), next_compute_tag pulses for 1 cycle, and compute_ptr advances. Otherwise the tag stays in COMPUTE_CHECK.
REQ-020 tag_reuse increments the count of the newest allocated non-flushed tag (alloc_ptr-1) and overwrites that tag's sideband registers.
REQ-021 tag_reuse with no eligible tag is ignored.
REQ-022 tag_reuse at count == 2^REUSE_CNT_W-1 is dropped and sets reuse_overflow.
REQ-023 tag_flush sets flushed on the newest non-flushed allocated tag. A flush with no eligible tag is ignored.
REQ-024 Same-cycle tag_req and tag_flush: the flush applies to the tag allocated before this request.
REQ-025 Same-cycle tag_req and tag_reuse: the reuse applies to the newly granted tag, giving count = 2.
REQ-026 Same-cycle tag_reuse and compute_tag_done on the same tag: count is unchanged.
REQ-027 stmem_tag_ready = tag[stmem_ptr] in STMEM. On stmem_tag_done: the tag -> FREE and stmem_ptr advances.
REQ-028 compute_bias_prev_sw is the bias register of tag[compute_ptr]. stmem_ddr_pe_sw is latched from the retiring tag's ddr register on the COMPUTE_CHECK -> STMEM transition.
REQ-029 All stage ready outputs are combinational from registered state. A state transition takes 1 cycle, so a tag is never ready for two stages in the same cycle.
REQ-030 All tags busy: tag_ready = 0, and tag_req is held without loss until a tag frees.

Reset
REQ-031 On reset: all tags FREE, all pointers 0, counts 0, flushed 0, sideband registers 0, reuse_overflow 0, tags_free = NUM_TAGS, every ready output 1 for tag_ready and 0 for the others, next_compute_tag 0.
REQ-032 Reset asserted mid-operation abandons all in-flight tags with no done pulses required; on the first cycle after reset, tag_ready = 1.

Structure
REQ-033 The tag state encodings (FREE=0, LDMEM=1, COMPUTE=2, COMPUTE_CHECK=3, STMEM=4) and the state width of 3 SHALL live in the shared package obuf_tag_pkg.
REQ-034 The per-tag state machine, counter, flags and sideband registers SHALL be one sub-module, obuf_tag_slot, instantiated NUM_TAGS times; pointer and mux logic stay in the top level.

Verification
REQ-035 NUM_TAGS=2: req, flush, ldmem_done, compute_done, stmem_done -> tag 0 walks every state, next_compute_tag pulses once, tags_free returns to 2.
REQ-036 NUM_TAGS=4: four reqs back-to-back with no done pulses -> alloc_tag_id 0,1,2,3; fifth request stalls with tag_ready=0 until stmem_done on tag 0.
REQ-037 req, reuse x2, flush -> exactly 3 compute_tag_ready windows on tag 0, with compute_bias_prev_sw following the latest reuse value.
REQ-038 REUSE_CNT_W=2: req plus 3 reuses -> count saturates at 3, reuse_overflow=1, and only 3 compute passes occur.
REQ-039 Same-cycle req and flush after an earlier tag 0 -> tag 0 is flushed and tag 1 is not; then reuse -> tag 1 count = 2.
REQ-040 STORE_ENABLED=0 with reset pulsed while tag 1 is in COMPUTE -> all tags FREE, tags_free = NUM_TAGS, and stmem_tag_ready is never asserted.

Source files
------------

// File: rtl/obuf_tag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obuf_tag_pkg
// Purpose  : Shared tag-state encoding and sizing helper for the output
//            buffer multi-tag controller.
// Revision : 1.0 - initial release
// ============================================================================
package obuf_tag_pkg;

  localparam int TAG_STATE_W = 3;

  typedef enum logic [TAG_STATE_W-1:0] {
    TAG_FREE          = 3'd0,
    TAG_LDMEM         = 3'd1,
    TAG_COMPUTE       = 3'd2,
    TAG_COMPUTE_CHECK = 3'd3,
    TAG_STMEM         = 3'd4
  } tag_state_e;

  // Tag-id width; never narrower than one bit.
  function automatic int tag_width(input int num_tags);
    return (num_tags <= 2) ? 1 : $clog2(num_tags);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obuf_multi_tag_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : obuf_multi_tag_ctrl_if
// Purpose  : Tag request / stage handshake bundle of the output-buffer
//            controller. master = requesting side, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface obuf_multi_tag_ctrl_if #(
  parameter int TAG_W = 1
);

  logic             tag_req;
  logic             tag_ready;
  logic [TAG_W-1:0] alloc_tag_id;
  logic             tag_reuse;
  logic             tag_flush;
  logic             tag_bias_prev_sw;
  logic             tag_ddr_pe_sw;

  logic             ldmem_tag_ready;
  logic [TAG_W-1:0] ldmem_tag_id;
  logic             ldmem_tag_done;

  logic             compute_tag_ready;
  logic [TAG_W-1:0] compute_tag_id;
  logic             compute_tag_done;
  logic             compute_bias_prev_sw;
  logic             next_compute_tag;

  logic             stmem_tag_ready;
  logic [TAG_W-1:0] stmem_tag_id;
  logic             stmem_tag_done;
  logic             stmem_ddr_pe_sw;

  logic [TAG_W:0]   tags_free;
  logic             reuse_overflow;

  modport master (
    output tag_req, tag_reuse, tag_flush, tag_bias_prev_sw, tag_ddr_pe_sw,
           ldmem_tag_done, compute_tag_done, stmem_tag_done,
    input  tag_ready, alloc_tag_id, ldmem_tag_ready, ldmem_tag_id,
           compute_tag_ready, compute_tag_id, compute_bias_prev_sw,
           next_compute_tag, stmem_tag_ready, stmem_tag_id, stmem_ddr_pe_sw,
           tags_free, reuse_overflow
  );

  modport slave (
    input  tag_req, tag_reuse, tag_flush, tag_bias_prev_sw, tag_ddr_pe_sw,
           ldmem_tag_done, compute_tag_done, stmem_tag_done,
    output tag_ready, alloc_tag_id, ldmem_tag_ready, ldmem_tag_id,
           compute_tag_ready, compute_tag_id, compute_bias_prev_sw,
           next_compute_tag, stmem_tag_ready, stmem_tag_id, stmem_ddr_pe_sw,
           tags_free, reuse_overflow
  );

endinterface
`default_nettype wire

// File: rtl/obuf_tag_slot.sv
`default_nettype none
// ============================================================================
// Module   : obuf_tag_slot
// Purpose  : One output-buffer tag: lifecycle state, pending-compute count,
//            flush flag and sideband registers. All inputs arrive pre-gated.
// Revision : 1.0 - initial release
// ============================================================================
module obuf_tag_slot
  import obuf_tag_pkg::*;
#(
  parameter int REUSE_CNT_W   = 3,
  parameter int STORE_ENABLED = 1
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   i_alloc,
  input  wire logic                   i_ld_done,
  input  wire logic                   i_cp_done,
  input  wire logic                   i_st_done,
  input  wire logic                   i_reuse,
  input  wire logic                   i_flush,
  input  wire logic                   i_bias,
  input  wire logic                   i_ddr,
  output tag_state_e                  o_state,
  output logic [REUSE_CNT_W-1:0]      o_count,
  output logic                        o_flushed,
  output logic                        o_bias,
  output logic                        o_ddr
);

  localparam logic [REUSE_CNT_W-1:0] c_ONE = REUSE_CNT_W'(1);
  localparam logic [REUSE_CNT_W-1:0] c_TWO = REUSE_CNT_W'(2);

  tag_state_e               r_state;
  logic [REUSE_CNT_W-1:0]   r_count;
  logic                     r_flushed;
  logic                     r_bias;
  logic                     r_ddr;
  logic [REUSE_CNT_W-1:0]   w_cnt_adj;

  // A reuse and a compute completion in the same cycle cancel out.
  always_comb begin
    w_cnt_adj = r_count;
    if (i_reuse && !i_cp_done) begin
      w_cnt_adj = r_count + c_ONE;
    end else if (!i_reuse && i_cp_done) begin
      w_cnt_adj = r_count - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= TAG_FREE;
      r_count   <= '0;
      r_flushed <= 1'b0;
      r_bias    <= 1'b0;
      r_ddr     <= 1'b0;
    end else begin
      if (i_flush) r_flushed <= 1'b1;
      if (i_reuse) begin
        r_bias <= i_bias;
        r_ddr  <= i_ddr;
      end
      if (r_state != TAG_FREE) r_count <= w_cnt_adj;
      case (r_state)
        TAG_FREE: begin
          if (i_alloc) begin
            r_state   <= TAG_LDMEM;
            r_count   <= i_reuse ? c_TWO : c_ONE;
            r_flushed <= 1'b0;
            r_bias    <= i_bias;
            r_ddr     <= i_ddr;
          end
        end
        TAG_LDMEM: begin
          if (i_ld_done) r_state <= TAG_COMPUTE;
        end
        TAG_COMPUTE: begin
          if (i_cp_done) r_state <= TAG_COMPUTE_CHECK;
        end
        TAG_COMPUTE_CHECK: begin
          if (r_count != '0) begin
            r_state <= TAG_COMPUTE;
          end else if (r_flushed) begin
            r_state <= (STORE_ENABLED != 0) ? TAG_STMEM : TAG_FREE;
          end
        end
        TAG_STMEM: begin
          if (i_st_done) r_state <= TAG_FREE;
        end
        default: r_state <= TAG_FREE;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_count   = r_count;
  assign o_flushed = r_flushed;
  assign o_bias    = r_bias;
  assign o_ddr     = r_ddr;

endmodule
`default_nettype wire

// File: rtl/obuf_multi_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : obuf_multi_tag_ctrl
// Purpose  : Round-robin output-buffer tag controller; tags move through
//            load / compute / store stages strictly in allocation order.
// Revision : 1.0 - initial release
// ============================================================================
module obuf_multi_tag_ctrl
  import obuf_tag_pkg::*;
#(
  parameter int NUM_TAGS      = 2,
  parameter int REUSE_CNT_W   = 3,
  parameter int STORE_ENABLED = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  obuf_multi_tag_ctrl_if.slave  bus
);

  localparam int TAG_W = tag_width(NUM_TAGS);
  localparam logic [REUSE_CNT_W-1:0] c_CNT_MAX = {REUSE_CNT_W{1'b1}};

  logic [TAG_W-1:0]       r_alloc_ptr;
  logic [TAG_W-1:0]       r_ldmem_ptr;
  logic [TAG_W-1:0]       r_compute_ptr;
  logic [TAG_W-1:0]       r_stmem_ptr;
  logic                   r_next_compute;
  logic                   r_stmem_ddr;
  logic                   r_overflow;

  tag_state_e             w_state   [NUM_TAGS];
  logic [REUSE_CNT_W-1:0] w_count   [NUM_TAGS];
  logic                   w_flushed [NUM_TAGS];
  logic                   w_bias    [NUM_TAGS];
  logic                   w_ddr     [NUM_TAGS];

  logic [TAG_W-1:0]       w_newest;
  logic                   w_newest_open;
  logic                   w_accept;
  logic                   w_ld_ready;
  logic                   w_cp_ready;
  logic                   w_st_ready;
  logic                   w_ld_fire;
  logic                   w_cp_fire;
  logic                   w_st_fire;
  logic                   w_retire;
  logic                   w_flush_hit;
  logic                   w_reuse_hit;
  logic                   w_reuse_sat;
  logic [TAG_W-1:0]       w_reuse_tgt;
  logic [TAG_W:0]         w_free_cnt;

  assign w_newest      = r_alloc_ptr - TAG_W'(1);
  assign w_newest_open = (w_state[w_newest] != TAG_FREE) && !w_flushed[w_newest];
  assign w_accept      = bus.tag_req && (w_state[r_alloc_ptr] == TAG_FREE);

  assign w_ld_ready = (w_state[r_ldmem_ptr]   == TAG_LDMEM);
  assign w_cp_ready = (w_state[r_compute_ptr] == TAG_COMPUTE);
  assign w_st_ready = (w_state[r_stmem_ptr]   == TAG_STMEM);
  assign w_ld_fire  = w_ld_ready && bus.ldmem_tag_done;
  assign w_cp_fire  = w_cp_ready && bus.compute_tag_done;
  assign w_st_fire  = w_st_ready && bus.stmem_tag_done;

  // Only the compute-pointer tag can be in the compute loop, so retirement is
  // judged there; the slot reaches the same decision from the same registers.
  assign w_retire = (w_state[r_compute_ptr] == TAG_COMPUTE_CHECK) &&
                    (w_count[r_compute_ptr] == '0) && w_flushed[r_compute_ptr];

  // Flush always targets the tag allocated before any same-cycle request.
  assign w_flush_hit = bus.tag_flush && w_newest_open;

  // A same-cycle request makes the freshly granted tag the reuse target.
  always_comb begin
    w_reuse_hit = 1'b0;
    w_reuse_sat = 1'b0;
    w_reuse_tgt = w_newest;
    if (bus.tag_reuse) begin
      if (w_accept) begin
        w_reuse_hit = 1'b1;
        w_reuse_tgt = r_alloc_ptr;
        w_reuse_sat = (REUSE_CNT_W < 2);
      end else if (w_newest_open) begin
        w_reuse_hit = 1'b1;
        w_reuse_sat = (w_count[w_newest] == c_CNT_MAX);
      end
    end
  end

  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_slot
    obuf_tag_slot #(
      .REUSE_CNT_W   (REUSE_CNT_W),
      .STORE_ENABLED (STORE_ENABLED)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_alloc   (w_accept    && (r_alloc_ptr   == TAG_W'(i))),
      .i_ld_done (w_ld_fire   && (r_ldmem_ptr   == TAG_W'(i))),
      .i_cp_done (w_cp_fire   && (r_compute_ptr == TAG_W'(i))),
      .i_st_done (w_st_fire   && (r_stmem_ptr   == TAG_W'(i))),
      .i_reuse   (w_reuse_hit && !w_reuse_sat && (w_reuse_tgt == TAG_W'(i))),
      .i_flush   (w_flush_hit && (w_newest      == TAG_W'(i))),
      .i_bias    (bus.tag_bias_prev_sw),
      .i_ddr     (bus.tag_ddr_pe_sw),
      .o_state   (w_state[i]),
      .o_count   (w_count[i]),
      .o_flushed (w_flushed[i]),
      .o_bias    (w_bias[i]),
      .o_ddr     (w_ddr[i])
    );
  end

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (w_state[i] == TAG_FREE) w_free_cnt = w_free_cnt + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alloc_ptr    <= '0;
      r_ldmem_ptr    <= '0;
      r_compute_ptr  <= '0;
      r_stmem_ptr    <= '0;
      r_next_compute <= 1'b0;
      r_stmem_ddr    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_accept)  r_alloc_ptr   <= r_alloc_ptr   + TAG_W'(1);
      if (w_ld_fire) r_ldmem_ptr   <= r_ldmem_ptr   + TAG_W'(1);
      if (w_retire)  r_compute_ptr <= r_compute_ptr + TAG_W'(1);
      if (w_st_fire) r_stmem_ptr   <= r_stmem_ptr   + TAG_W'(1);
      r_next_compute <= w_retire;
      if (w_retire && (STORE_ENABLED != 0)) r_stmem_ddr <= w_ddr[r_compute_ptr];
      if (w_reuse_hit && w_reuse_sat) r_overflow <= 1'b1;
    end
  end

  assign bus.tag_ready            = (w_state[r_alloc_ptr] == TAG_FREE);
  assign bus.alloc_tag_id         = r_alloc_ptr;
  assign bus.ldmem_tag_ready      = w_ld_ready;
  assign bus.ldmem_tag_id         = r_ldmem_ptr;
  assign bus.compute_tag_ready    = w_cp_ready;
  assign bus.compute_tag_id       = r_compute_ptr;
  assign bus.compute_bias_prev_sw = w_bias[r_compute_ptr];
  assign bus.next_compute_tag     = r_next_compute;
  assign bus.stmem_tag_ready      = w_st_ready;
  assign bus.stmem_tag_id         = r_stmem_ptr;
  assign bus.stmem_ddr_pe_sw      = r_stmem_ddr;
  assign bus.tags_free            = w_free_cnt;
  assign bus.reuse_overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_obuf_multi_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_obuf_multi_tag_ctrl
// Purpose  : Directed self-checking bench; DUT A = 4 tags / 2-bit count with
//            store, DUT B = 2 tags without store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obuf_multi_tag_ctrl;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   win_a [4];
  int   pulses_a;
  logic bias_and_a;
  logic b_st_seen = 1'b0;

  always #5 clk = ~clk;

  obuf_multi_tag_ctrl_if #(.TAG_W(2)) bus_a ();
  obuf_multi_tag_ctrl_if #(.TAG_W(1)) bus_b ();

  obuf_multi_tag_ctrl #(.NUM_TAGS(4), .REUSE_CNT_W(2), .STORE_ENABLED(1)) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  obuf_multi_tag_ctrl #(.NUM_TAGS(2), .REUSE_CNT_W(3), .STORE_ENABLED(0)) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  always @(negedge clk) if (bus_b.stmem_tag_ready === 1'b1) b_st_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step();
    step();
    rst_a = 1'b0;
  endtask

  // Acknowledge every stage as soon as it is ready, tallying compute windows.
  task automatic drain_a(input int cycles);
    for (int t = 0; t < 4; t++) win_a[t] = 0;
    pulses_a   = 0;
    bias_and_a = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (bus_a.compute_tag_ready) begin
        win_a[bus_a.compute_tag_id]++;
        bias_and_a = bias_and_a & bus_a.compute_bias_prev_sw;
      end
      if (bus_a.next_compute_tag) pulses_a++;
      bus_a.ldmem_tag_done   = bus_a.ldmem_tag_ready;
      bus_a.compute_tag_done = bus_a.compute_tag_ready;
      bus_a.stmem_tag_done   = bus_a.stmem_tag_ready;
      step();
    end
    bus_a.ldmem_tag_done   = 1'b0;
    bus_a.compute_tag_done = 1'b0;
    bus_a.stmem_tag_done   = 1'b0;
  endtask

  initial begin
    {bus_a.tag_req, bus_a.tag_reuse, bus_a.tag_flush, bus_a.tag_bias_prev_sw,
     bus_a.tag_ddr_pe_sw, bus_a.ldmem_tag_done, bus_a.compute_tag_done,
     bus_a.stmem_tag_done} = '0;
    {bus_b.tag_req, bus_b.tag_reuse, bus_b.tag_flush, bus_b.tag_bias_prev_sw,
     bus_b.tag_ddr_pe_sw, bus_b.ldmem_tag_done, bus_b.compute_tag_done,
     bus_b.stmem_tag_done} = '0;
    step();
    rst_b = 1'b0;
    reset_a();

    // Reset state
    check("rst_tag_ready", bus_a.tag_ready, 1);
    check("rst_tags_free", bus_a.tags_free, 4);
    check("rst_alloc_id", bus_a.alloc_tag_id, 0);
    check("rst_ld_ready", bus_a.ldmem_tag_ready, 0);
    check("rst_cp_ready", bus_a.compute_tag_ready, 0);
    check("rst_st_ready", bus_a.stmem_tag_ready, 0);
    check("rst_next", bus_a.next_compute_tag, 0);
    check("rst_ovf", bus_a.reuse_overflow, 0);

    // Single tag walks every state
    bus_a.tag_req = 1'b1; bus_a.tag_bias_prev_sw = 1'b1; bus_a.tag_ddr_pe_sw = 1'b1;
    step();
    bus_a.tag_req = 1'b0; bus_a.tag_bias_prev_sw = 1'b0; bus_a.tag_ddr_pe_sw = 1'b0;
    check("walk_free3", bus_a.tags_free, 3);
    check("walk_alloc1", bus_a.alloc_tag_id, 1);
    check("walk_ld_ready", bus_a.ldmem_tag_ready, 1);
    check("walk_ld_id", bus_a.ldmem_tag_id, 0);
    bus_a.tag_flush = 1'b1; step(); bus_a.tag_flush = 1'b0;
    bus_a.ldmem_tag_done = 1'b1; step(); bus_a.ldmem_tag_done = 1'b0;
    check("walk_ld_gone", bus_a.ldmem_tag_ready, 0);
    check("walk_cp_ready", bus_a.compute_tag_ready, 1);
    check("walk_cp_id", bus_a.compute_tag_id, 0);
    check("walk_cp_bias", bus_a.compute_bias_prev_sw, 1);
    bus_a.compute_tag_done = 1'b1; step(); bus_a.compute_tag_done = 1'b0;
    check("walk_check_cp", bus_a.compute_tag_ready, 0);
    check("walk_check_next", bus_a.next_compute_tag, 0);
    step();
    check("walk_next_pulse", bus_a.next_compute_tag, 1);
    check("walk_st_ready", bus_a.stmem_tag_ready, 1);
    check("walk_st_id", bus_a.stmem_tag_id, 0);
    check("walk_st_ddr", bus_a.stmem_ddr_pe_sw, 1);
    step();
    check("walk_next_low", bus_a.next_compute_tag, 0);
    bus_a.stmem_tag_done = 1'b1; step(); bus_a.stmem_tag_done = 1'b0;
    check("walk_free4", bus_a.tags_free, 4);
    check("walk_st_gone", bus_a.stmem_tag_ready, 0);

    // Fill all four tags; same-cycle flush lands on the previous tag
    reset_a();
    for (int i = 0; i < 4; i++) begin
      check("fill_id", bus_a.alloc_tag_id, i);
      check("fill_ready", bus_a.tag_ready, 1);
      bus_a.tag_req = 1'b1; bus_a.tag_flush = (i > 0);
      step();
    end
    check("full_ready", bus_a.tag_ready, 0);
    check("full_free", bus_a.tags_free, 0);
    step();
    bus_a.tag_flush = 1'b0;
    check("stall_ready", bus_a.tag_ready, 0);
    bus_a.stmem_tag_done = 1'b1; step(); bus_a.stmem_tag_done = 1'b0;
    check("stray_st_done", bus_a.tags_free, 0);
    bus_a.ldmem_tag_done = 1'b1; step(); bus_a.ldmem_tag_done = 1'b0;
    bus_a.compute_tag_done = 1'b1; step(); bus_a.compute_tag_done = 1'b0;
    step();
    check("stall_st_ready", bus_a.stmem_tag_ready, 1);
    check("stall_ready2", bus_a.tag_ready, 0);
    bus_a.stmem_tag_done = 1'b1; step(); bus_a.stmem_tag_done = 1'b0;
    check("unstall_ready", bus_a.tag_ready, 1);
    check("unstall_id", bus_a.alloc_tag_id, 0);
    step();
    bus_a.tag_req = 1'b0;
    check("regrant_ready", bus_a.tag_ready, 0);
    check("regrant_id", bus_a.alloc_tag_id, 1);

    // Two reuses -> three compute passes, bias from the latest reuse
    reset_a();
    bus_a.tag_req = 1'b1; step(); bus_a.tag_req = 1'b0;
    bus_a.tag_reuse = 1'b1; step();
    bus_a.tag_bias_prev_sw = 1'b1; step();
    bus_a.tag_reuse = 1'b0; bus_a.tag_bias_prev_sw = 1'b0;
    bus_a.tag_flush = 1'b1; step(); bus_a.tag_flush = 1'b0;
    check("reuse2_ovf", bus_a.reuse_overflow, 0);
    drain_a(30);
    check("reuse2_windows", win_a[0], 3);
    check("reuse2_bias", bias_and_a, 1);
    check("reuse2_pulses", pulses_a, 1);
    check("reuse2_free", bus_a.tags_free, 4);

    // Counter saturation at 3
    reset_a();
    bus_a.tag_req = 1'b1; step(); bus_a.tag_req = 1'b0;
    bus_a.tag_reuse = 1'b1;
    step(); step();
    check("sat_pre_ovf", bus_a.reuse_overflow, 0);
    step();
    bus_a.tag_reuse = 1'b0;
    check("sat_ovf", bus_a.reuse_overflow, 1);
    bus_a.tag_flush = 1'b1; step(); bus_a.tag_flush = 1'b0;
    drain_a(30);
    check("sat_windows", win_a[0], 3);
    check("sat_ovf_sticky", bus_a.reuse_overflow, 1);

    // Same-cycle req+flush flushes tag 0; reuse then lands on tag 1
    reset_a();
    bus_a.tag_req = 1'b1; step();
    bus_a.tag_flush = 1'b1; step();
    bus_a.tag_req = 1'b0; bus_a.tag_flush = 1'b0;
    bus_a.tag_reuse = 1'b1; step(); bus_a.tag_reuse = 1'b0;
    bus_a.tag_flush = 1'b1; step(); bus_a.tag_flush = 1'b0;
    drain_a(40);
    check("pair_win0", win_a[0], 1);
    check("pair_win1", win_a[1], 2);
    check("pair_pulses", pulses_a, 2);
    check("pair_free", bus_a.tags_free, 4);

    // DUT B: no store stage, reset while tag 1 computes
    bus_b.tag_req = 1'b1; step();
    bus_b.tag_flush = 1'b1; step();
    bus_b.tag_req = 1'b0; step();
    bus_b.tag_flush = 1'b0;
    for (int c = 0; c < 20 && !(bus_b.compute_tag_ready && bus_b.compute_tag_id == 1'b1); c++) begin
      bus_b.ldmem_tag_done   = bus_b.ldmem_tag_ready;
      bus_b.compute_tag_done = bus_b.compute_tag_ready;
      step();
    end
    bus_b.ldmem_tag_done = 1'b0; bus_b.compute_tag_done = 1'b0;
    check("nost_reach_t1", bus_b.compute_tag_ready && (bus_b.compute_tag_id == 1'b1), 1);
    check("nost_free1", bus_b.tags_free, 1);
    rst_b = 1'b1; step(); rst_b = 1'b0;
    check("nost_rst_ready", bus_b.tag_ready, 1);
    check("nost_rst_free", bus_b.tags_free, 2);
    check("nost_rst_cp", bus_b.compute_tag_ready, 0);
    check("nost_rst_ld", bus_b.ldmem_tag_ready, 0);
    check("nost_rst_id", bus_b.alloc_tag_id, 0);
    step();
    check("nost_never_st", b_st_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
